// File: rtl/sign_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sign_ext_pkg
// Brief    : Shared widths and extension-mode encoding for the sign_ext unit.
// Revision : 1.0 - initial release
// ============================================================================
package sign_ext_pkg;

    localparam int DATA_W = 16;
    localparam int IMM7_W = 7;

    localparam logic EXT_SIGN = 1'b0;
    localparam logic EXT_ZERO = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sign_ext_core.sv
`default_nettype none
// ============================================================================
// Module   : sign_ext_core
// Brief    : Combinational sign/zero extension of an IN_WIDTH field.
// Revision : 1.0 - initial release
// ============================================================================
module sign_ext_core
    import sign_ext_pkg::*;
#(
    parameter int IN_WIDTH  = IMM7_W,
    parameter int OUT_WIDTH = DATA_W
) (
    input  logic [IN_WIDTH-1:0]  a,
    input  logic                 zext,
    output logic [OUT_WIDTH-1:0] y_next
);

    generate
        if (IN_WIDTH == OUT_WIDTH) begin : g_pass
            // No upper bits to fill, so the mode select is irrelevant here.
            logic w_unused_zext;
            assign w_unused_zext = zext;
            assign y_next        = a;
        end else begin : g_extend
            logic w_fill;
            assign w_fill = (zext == EXT_SIGN) & a[IN_WIDTH-1];
            assign y_next = {{(OUT_WIDTH-IN_WIDTH){w_fill}}, a};
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sign_ext.sv
`default_nettype none
// ============================================================================
// Module   : sign_ext
// Brief    : Registered immediate extension with a one-cycle valid qualifier.
// Revision : 1.0 - initial release
// ============================================================================
module sign_ext
    import sign_ext_pkg::*;
#(
    parameter int IN_WIDTH  = IMM7_W,
    parameter int OUT_WIDTH = DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  a,
    input  logic                 zext,
    input  logic                 in_valid,
    output logic [OUT_WIDTH-1:0] y,
    output logic                 out_valid
);

    generate
        if (IN_WIDTH < 1 || IN_WIDTH > OUT_WIDTH) begin : g_bad_width
            $error("sign_ext: IN_WIDTH must be in 1..OUT_WIDTH");
        end
    endgenerate

    logic [OUT_WIDTH-1:0] w_y_next;
    logic [OUT_WIDTH-1:0] r_y;
    logic                 r_out_valid;

    sign_ext_core #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_core (
        .a      (a),
        .zext   (zext),
        .y_next (w_y_next)
    );

    // y keeps its last result across bubbles; only the qualifier drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_y <= w_y_next;
            end
        end
    end

    assign y         = r_y;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_sign_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_sign_ext
// Brief    : Directed self-checking bench for sign_ext (7, 16 and 1-bit inputs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sign_ext;

    logic        clk;
    logic        rst;
    logic        zext;
    logic        in_valid;
    logic [6:0]  a7;
    logic [15:0] a16;
    logic [0:0]  a1;
    logic [15:0] y7, y16, y1;
    logic        ov7, ov16, ov1;

    int checks;
    int errors;

    sign_ext #(.IN_WIDTH(7), .OUT_WIDTH(16)) u_dut7 (
        .clk(clk), .rst(rst), .a(a7), .zext(zext), .in_valid(in_valid),
        .y(y7), .out_valid(ov7)
    );

    sign_ext #(.IN_WIDTH(16), .OUT_WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .a(a16), .zext(zext), .in_valid(in_valid),
        .y(y16), .out_valid(ov16)
    );

    sign_ext #(.IN_WIDTH(1), .OUT_WIDTH(16)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .zext(zext), .in_valid(in_valid),
        .y(y1), .out_valid(ov1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; results are sampled at
    // the same offset after the edge that registers them.
    task automatic beat(input logic [6:0] av, input logic z, input logic v);
        a7       = av;
        zext     = z;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] src;

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        zext     = 1'b0;
        in_valid = 1'b0;
        a7       = '0;
        a16      = '0;
        a1       = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_y", y7, 16'h0000);
        check("reset_valid", {15'd0, ov7}, 16'h0000);
        rst = 1'b0;

        beat(7'd50, 1'b0, 1'b1);
        check("sext_pos_y", y7, 16'h0032);
        check("sext_pos_valid", {15'd0, ov7}, 16'h0001);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_y", y7, 16'h0000);
        check("async_rst_valid", {15'd0, ov7}, 16'h0000);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_y", y7, 16'h0000);
        check("post_rst_valid", {15'd0, ov7}, 16'h0000);

        src = 8'd250;
        beat(src[6:0], 1'b0, 1'b1);
        check("sext_trunc250", y7, 16'hFFFA);
        beat(7'h40, 1'b0, 1'b1);
        check("sext_min_neg", y7, 16'hFFC0);
        beat(7'h3F, 1'b0, 1'b1);
        check("sext_max_pos", y7, 16'h003F);
        beat(7'h7F, 1'b0, 1'b1);
        check("sext_all_ones", y7, 16'hFFFF);
        beat(7'h7A, 1'b1, 1'b1);
        check("zext_7a", y7, 16'h007A);
        beat(7'h40, 1'b1, 1'b1);
        check("zext_40", y7, 16'h0040);

        beat(7'h01, 1'b0, 1'b1);
        check("seq_b1_y", y7, 16'h0001);
        check("seq_b1_valid", {15'd0, ov7}, 16'h0001);
        beat(7'h7E, 1'b0, 1'b1);
        check("seq_b2_y", y7, 16'hFFFE);
        check("seq_b2_valid", {15'd0, ov7}, 16'h0001);
        beat(7'h15, 1'b1, 1'b0);
        check("bubble_valid", {15'd0, ov7}, 16'h0000);
        check("bubble_hold_y", y7, 16'hFFFE);

        a16 = 16'h8001;
        a1  = 1'b1;
        beat(7'h00, 1'b0, 1'b1);
        check("w16_sext", y16, 16'h8001);
        check("w1_sext", y1, 16'hFFFF);
        check("w1_valid", {15'd0, ov1}, 16'h0001);
        beat(7'h00, 1'b1, 1'b1);
        check("w16_zext", y16, 16'h8001);
        check("w16_valid", {15'd0, ov16}, 16'h0001);
        check("w1_zext", y1, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sign_ext.md
Name:
sign_ext

Overview:
- Parameterised immediate-extension unit: widens an IN_WIDTH-bit field (e.g. 7-bit instruction immediate) to an OUT_WIDTH-bit datapath word.
- Sign-extends by default; zero-extends on request.
- Result is registered: one-cycle latency with a valid qualifier.
- Sits between instruction decode and the ALU operand mux.

Parameters:
- IN_WIDTH, 7, width of input field a; legal range 1..OUT_WIDTH.
- OUT_WIDTH, 16, width of extended result y.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- a  input  IN_WIDTH  field to extend; bit IN_WIDTH-1 is the sign bit
- zext  input  1  0 = sign-extend, 1 = zero-extend
- in_valid  input  1  a/zext are valid this cycle
- y  output  OUT_WIDTH  extended result (registered)
- out_valid  output  1  y holds the result of the in_valid beat from the previous cycle

Behaviour:
- Reset: while rst=1, y=0 and out_valid=0 immediately (asynchronous), held until rst deasserts.
- Extension rule, computed combinationally from a and zext:
  - y_next[IN_WIDTH-1:0] = a.
  - y_next[OUT_WIDTH-1:IN_WIDTH] = all copies of a[IN_WIDTH-1] when zext=0, all zeros when zext=1.
- Registering on each rising clk edge:
  - if in_valid=1: y <= y_next, out_valid <= 1.
  - if in_valid=0: y holds its previous value, out_valid <= 0.
- Latency: exactly 1 cycle from in_valid to out_valid.
- Throughput: one result per cycle; back-to-back in_valid beats give continuous out_valid.
- IN_WIDTH == OUT_WIDTH: pure registered pass-through; zext has no effect.
- IN_WIDTH > OUT_WIDTH or IN_WIDTH < 1: elaboration-time error.
- Values wider than IN_WIDTH driven by the source are truncated to their low IN_WIDTH bits before reaching a (e.g. 250 arrives as 7'b1111010).
- Reset mid-stream: the pending result is discarded, and out_valid is 0 in the first cycle after release.
- No handshake backpressure; the downstream stage must accept every out_valid beat.

Decomposition:
- Shared package:
  - DATA_W = 16 and IMM7_W = 7 constants.
  - Localparams EXT_SIGN = 1'b0 and EXT_ZERO = 1'b1 for the zext encoding.
- One natural sub-module, sign_ext_core:
  - Purely combinational; a, zext -> y_next.
  - Instantiated inside sign_ext, which adds the output register and the valid flop.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> y=16'h0000 and out_valid=0 immediately. Release, in_valid=0 -> outputs stay 0.
- Positive sign-extend: a=7'd50 (0110010), zext=0, in_valid=1 -> next cycle y=16'h0032, out_valid=1.
- Negative sign-extend: source value 250 truncated to a=7'h7A, zext=0 -> y=16'hFFFA (-6). Boundary cases:
  - a=7'h40 -> 16'hFFC0.
  - a=7'h3F -> 16'h003F.
  - a=7'h7F -> 16'hFFFF.
- Zero-extend: a=7'h7A, zext=1 -> y=16'h007A; a=7'h40, zext=1 -> 16'h0040.
- Valid/hold sequence, beats on consecutive cycles:
  - beats a=7'h01, then 7'h7E, then a bubble -> y=16'h0001 then 16'hFFFE, with out_valid 1,1.
  - in the bubble cycle, out_valid=0 and y holds 16'hFFFE.
- Parameter sweep: IN_WIDTH=16 -> pass-through, zext ignored. IN_WIDTH=1, a=1 -> 16'hFFFF (sign) / 16'h0001 (zero).
